// File: rtl/data_ingress_mc_if.sv
// AXI-Stream bundle carrying per-channel sample beats with the channel ID on tuser.
interface data_ingress_mc_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [CH_W-1:0]   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/data_ingress_mc.sv
// Multi-channel ingress generator: NUM_CH monotonic sample counters streamed as
// FRAME_LEN-beat AXI-Stream frames, channels picked round-robin from ch_mask.
module data_ingress_mc #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_CH    = 4,
  parameter int          FRAME_LEN = 16,
  parameter logic [31:0] INC       = 32'h0001_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_mask,
  data_ingress_mc_if.master    m,
  output logic                 busy,
  output logic [15:0]          frames_sent
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [DATA_W-1:0] INC_W    = DATA_W'(INC);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARB, STREAM} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] cnt [NUM_CH];
  logic [CH_W-1:0]   last_ch;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   scan;
  logic              grant_ok;
  logic              hs;
  logic              is_last;

  // last_ch doubles as the active channel while streaming, since it is loaded with the grant
  assign hs      = (state == STREAM) && m.tready;
  assign is_last = (beat_cnt == BEAT_END);

  // Round-robin search starting at the channel after last_ch
  always_comb begin
    grant    = last_ch;
    grant_ok = 1'b0;
    scan     = last_ch;
    for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
      scan = (scan == CH_LAST) ? '0 : scan + 1'b1;
      if (!grant_ok && ch_mask[scan]) begin
        grant_ok = 1'b1;
        grant    = scan;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (enable) state_nx = ARB;
      ARB:    if (!enable) state_nx = IDLE;
              else if (grant_ok) state_nx = STREAM;
      STREAM: if (hs && is_last) state_nx = enable ? ARB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: everything derives from registered state, so tvalid never sees tready
  always_comb begin
    m.tvalid = 1'b0;
    m.tdata  = '0;
    m.tlast  = 1'b0;
    m.tuser  = '0;
    busy     = (state != IDLE);
    if (state == STREAM) begin
      m.tvalid = 1'b1;
      m.tdata  = cnt[last_ch];
      m.tlast  = is_last;
      m.tuser  = last_ch;
    end
  end

  // Datapath: grant capture, per-channel counters, beat and frame counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) cnt[i] <= '0;
      last_ch     <= CH_LAST;
      beat_cnt    <= '0;
      frames_sent <= '0;
    end else begin
      if (state == ARB && enable && grant_ok) last_ch <= grant;
      if (hs) begin
        cnt[last_ch] <= cnt[last_ch] + INC_W;
        if (is_last) begin
          beat_cnt    <= '0;
          frames_sent <= frames_sent + 16'd1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_ingress_mc.sv
// Randomised scoreboard bench for data_ingress_mc plus a narrow single-channel instance.
module tb_data_ingress_mc;
  localparam int          DW  = 32;
  localparam int          NCH = 4;
  localparam int          FL  = 4;
  localparam logic [31:0] INC = 32'h0001_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic [NCH-1:0] ch_mask;
  logic busy;
  logic [15:0] frames_sent;

  logic enable8;
  logic [0:0] ch_mask8;
  logic busy8;
  logic [15:0] frames8;

  data_ingress_mc_if #(.DATA_W(DW), .NUM_CH(NCH)) m_if ();
  data_ingress_mc_if #(.DATA_W(8), .NUM_CH(1)) if8 ();

  data_ingress_mc #(.DATA_W(DW), .NUM_CH(NCH), .FRAME_LEN(FL), .INC(INC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .m(m_if.master), .busy(busy), .frames_sent(frames_sent)
  );

  data_ingress_mc #(.DATA_W(8), .NUM_CH(1), .FRAME_LEN(1), .INC(32'h0000_00FF)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable8), .ch_mask(ch_mask8),
    .m(if8.master), .busy(busy8), .frames_sent(frames8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int acc_frames = 0;
  int acc_beat = 0;
  int tready_pct = 100;

  logic [31:0] mdl_cnt [NCH];
  int          mdl_last;
  logic [15:0] exp_frames;

  // Reference model: whole frames predicted from the round-robin rule
  task automatic predict(input logic [NCH-1:0] mask, input int k);
    for (int f = 0; f < k; f++) begin
      int c;
      c = mdl_last;
      for (int i = 1; i <= NCH; i++) begin
        if (mask[(mdl_last + i) % NCH]) begin
          c = (mdl_last + i) % NCH;
          break;
        end
      end
      mdl_last = c;
      for (int b = 0; b < FL; b++) begin
        exp_q.push_back('{data: mdl_cnt[c], user: 2'(c), last: (b == FL - 1)});
        mdl_cnt[c] = mdl_cnt[c] + INC;
      end
      exp_frames = exp_frames + 16'd1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mdl_cnt[i] = '0;
    mdl_last   = NCH - 1;
    exp_frames = '0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Random back-pressure, changed away from both clock edges
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_if.tready = ($urandom_range(0, 99) < tready_pct);
    end
  end

  // Monitor: compares each beat that will be accepted on the coming edge
  logic        stall;
  logic [31:0] h_data;
  logic [1:0]  h_user;
  logic        h_last;
  initial stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall    = 1'b0;
      acc_beat = 0;
    end else begin
      if (stall) begin
        checks++;
        if (!m_if.tvalid || m_if.tdata !== h_data || m_if.tuser !== h_user || m_if.tlast !== h_last) begin
          errors++;
          $display("FAIL hold: got v=%0b d=%h u=%0d l=%0b, need v=1 d=%h u=%0d l=%0b",
                   m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, h_data, h_user, h_last);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        beat_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got d=%h u=%0d l=%0b, need no beat",
                   m_if.tdata, m_if.tuser, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_if.tdata !== e.data || m_if.tuser !== e.user || m_if.tlast !== e.last) begin
            errors++;
            $display("FAIL beat: got d=%h u=%0d l=%0b, need d=%h u=%0d l=%0b",
                     m_if.tdata, m_if.tuser, m_if.tlast, e.data, e.user, e.last);
          end
        end
        acc_beat++;
        if (m_if.tlast) begin
          acc_frames++;
          acc_beat = 0;
        end
        stall = 1'b0;
      end else if (m_if.tvalid) begin
        stall  = 1'b1;
        h_data = m_if.tdata;
        h_user = m_if.tuser;
        h_last = m_if.tlast;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic wait_until(input int target, input int beat_min, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (acc_frames > target || (acc_frames == target && acc_beat >= beat_min)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got frames=%0d beat=%0d, need frames=%0d beat>=%0d",
               name, acc_frames, acc_beat, target, beat_min);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (m_if.tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== exp_frames) begin
      errors++;
      $display("FAIL %s: got v=%0b busy=%0b frames=%0d, need v=0 busy=0 frames=%0d",
               name, m_if.tvalid, busy, frames_sent, exp_frames);
    end
  endtask

  // Run k frames on mask; enable and mask drop after the first beat of the final frame
  task automatic run_frames(input logic [NCH-1:0] mask, input int k, input string name);
    int target;
    ch_mask = mask;
    predict(mask, k);
    target = acc_frames + k;
    enable = 1'b1;
    wait_until(target - 1, 1, {name, "_last_start"});
    enable  = 1'b0;
    ch_mask = '0;
    wait_until(target, 0, {name, "_done"});
    repeat (3) tick();
    check_idle({name, "_idle"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp8;
    int n8;
    rst_n    = 1'b0;
    enable   = 1'b0;
    ch_mask  = '0;
    enable8  = 1'b0;
    ch_mask8 = 1'b1;
    if8.tready = 1'b1;
    model_reset();
    repeat (3) tick();

    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tuser !== '0 || m_if.tlast !== 1'b0 ||
        busy !== 1'b0 || frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset: got v=%0b d=%h u=%0d l=%0b busy=%0b frames=%0d, need all 0",
               m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, busy, frames_sent);
    end
    rst_n = 1'b1;
    tick();

    tready_pct = 100;
    run_frames(4'b1111, 5, "all_ch");
    run_frames(4'b0101, 4, "even_ch");
    run_frames(4'b0010, 2, "ch1_resume");

    tready_pct = 50;
    run_frames(4'b1111, 6, "bp_all");
    run_frames(4'b1011, 3, "bp_1011");
    run_frames(4'b1000, 1, "bp_single");

    // Empty mask parks in ARB
    tready_pct = 100;
    ch_mask = '0;
    enable  = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mask_zero: got busy=%0b v=%0b, need busy=1 v=0", busy, m_if.tvalid);
    end
    enable = 1'b0;
    repeat (2) tick();
    check_idle("mask_zero_exit");

    // Reset in the middle of a frame
    ch_mask = 4'b1111;
    predict(4'b1111, 3);
    enable = 1'b1;
    wait_until(acc_frames + 1, 2, "pre_reset");
    rst_n  = 1'b0;
    enable = 1'b0;
    model_reset();
    tick();
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tuser !== '0 || m_if.tlast !== 1'b0 ||
        busy !== 1'b0 || frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b d=%h u=%0d l=%0b busy=%0b frames=%0d, need all 0",
               m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, busy, frames_sent);
    end
    rst_n = 1'b1;
    tick();
    run_frames(4'b1111, 2, "after_reset");

    // Narrow instance: one ARB cycle, then FRAME_LEN=1 beats with 8-bit wrap
    enable8 = 1'b1;
    tick();
    checks++;
    if (busy8 !== 1'b1 || if8.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL arb_cycle: got busy=%0b v=%0b, need busy=1 v=0", busy8, if8.tvalid);
    end
    tick();
    checks++;
    if (if8.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL first_valid: got v=%0b, need v=1", if8.tvalid);
    end
    exp8 = 8'h00;
    n8   = 0;
    for (int c = 0; c < 20 && n8 < 3; c++) begin
      if (if8.tvalid) begin
        checks++;
        if (if8.tdata !== exp8 || if8.tlast !== 1'b1 || if8.tuser !== 1'b0) begin
          errors++;
          $display("FAIL wrap8_beat%0d: got d=%h l=%0b u=%0d, need d=%h l=1 u=0",
                   n8, if8.tdata, if8.tlast, if8.tuser, exp8);
        end
        exp8 = exp8 + 8'hFF;
        n8++;
        if (n8 == 3) enable8 = 1'b0;
      end
      tick();
    end
    repeat (2) tick();
    checks++;
    if (n8 != 3 || frames8 !== 16'd3 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap8_end: got beats=%0d frames=%0d busy=%0b, need beats=3 frames=3 busy=0",
               n8, frames8, busy8);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending beats, need 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
